// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 8-digit 7-segment scan and rebuilds the 32-bit displayed value.
// Optional macro SEG_DEC_DP_EN enables decimal-point capture; otherwise the DP line is ignored.
`default_nettype none

module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an_i,
    input  logic [7:0]  seg_i,
    input  logic        clr_err_i,
    output logic [31:0] word_o,
    output logic [7:0]  dp_o,
    output logic        frame_valid_o,
    output logic [7:0]  digit_mask_o,
    output logic        err_o
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_TOP = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 2);

    state_t      state_q;
    logic [7:0]  s_an_q;
    logic [7:0]  s_seg_q;
    logic [7:0]  p_an_q;
    logic [7:0]  p_seg_q;
    logic [7:0]  cnt_q;
    logic [31:0] stage_q;
    logic [7:0]  sdp_q;
    logic [7:0]  mask_q;
    logic [31:0] word_q;
    logic [7:0]  dp_q;
    logic        fv_q;
    logic        err_q;

    logic [7:0]  seg_in_w;
    logic        dp_bit_w;
    logic        same_w;
    logic        accept_w;
    logic [3:0]  zeros_w;
    logic [2:0]  idx_w;
    logic [3:0]  nib_w;
    logic        seg_ok_w;
    logic        digit_ok_w;
    logic        err_new_w;
    logic [31:0] stage_d;
    logic [7:0]  sdp_d;
    logic [7:0]  mask_d;

`ifdef SEG_DEC_DP_EN
    assign seg_in_w = seg_i;
    assign dp_bit_w = ~s_seg_q[7];
`else
    // DP is stripped before sampling so it can never disturb the stability filter.
    assign seg_in_w = seg_i & 8'h7F;
    assign dp_bit_w = 1'b0;
`endif

    assign same_w   = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);
    assign accept_w = same_w && (cnt_q == CNT_PRE);
    assign zeros_w  = 4'($countones(~s_an_q));

    always_comb begin
        idx_w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!s_an_q[i]) begin
                idx_w = 3'(i);
            end
        end
    end

    always_comb begin
        nib_w    = 4'h0;
        seg_ok_w = 1'b1;
        case (s_seg_q[6:0])
            7'h40:   nib_w = 4'h0;
            7'h79:   nib_w = 4'h1;
            7'h24:   nib_w = 4'h2;
            7'h30:   nib_w = 4'h3;
            7'h19:   nib_w = 4'h4;
            7'h12:   nib_w = 4'h5;
            7'h02:   nib_w = 4'h6;
            7'h78:   nib_w = 4'h7;
            7'h00:   nib_w = 4'h8;
            7'h10:   nib_w = 4'h9;
            7'h08:   nib_w = 4'hA;
            7'h03:   nib_w = 4'hB;
            7'h46:   nib_w = 4'hC;
            7'h21:   nib_w = 4'hD;
            7'h06:   nib_w = 4'hE;
            7'h0E:   nib_w = 4'hF;
            default: seg_ok_w = 1'b0;
        endcase
    end

    assign digit_ok_w = accept_w && (zeros_w == 4'd1);
    assign err_new_w  = accept_w && ((zeros_w > 4'd1) || ((zeros_w == 4'd1) && !seg_ok_w));

    // Staging contents as they would look with the current digit merged in.
    always_comb begin
        stage_d                     = stage_q;
        stage_d[{idx_w, 2'b00} +: 4] = nib_w;
        sdp_d                       = sdp_q;
        sdp_d[idx_w]                = dp_bit_w;
        mask_d                      = mask_q | (8'h01 << idx_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_an_q  <= 8'hFF;
            s_seg_q <= 8'h00;
            p_an_q  <= 8'hFF;
            p_seg_q <= 8'h00;
            cnt_q   <= 8'd0;
            stage_q <= 32'h0;
            sdp_q   <= 8'h00;
            mask_q  <= 8'h00;
            word_q  <= 32'h0;
            dp_q    <= 8'h00;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s_an_q  <= an_i;
            s_seg_q <= seg_in_w;
            p_an_q  <= s_an_q;
            p_seg_q <= s_seg_q;
            if (!same_w) begin
                cnt_q <= 8'd0;
            end else if (cnt_q < CNT_TOP) begin
                cnt_q <= cnt_q + 8'd1;
            end
            err_q <= (err_q & ~clr_err_i) | err_new_w;
            fv_q  <= 1'b0;
            if (digit_ok_w) begin
                case (state_q)
                    IDLE: begin
                        if (idx_w == 3'd0) begin
                            stage_q <= stage_d;
                            sdp_q   <= sdp_d;
                            mask_q  <= 8'h01;
                            state_q <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        stage_q <= stage_d;
                        sdp_q   <= sdp_d;
                        if (idx_w == 3'd0) begin
                            mask_q <= 8'h01;
                        end else if (mask_d == 8'hFF) begin
                            word_q <= stage_d;
                            dp_q   <= sdp_d;
                            fv_q   <= 1'b1;
                            mask_q <= 8'h00;
                        end else begin
                            mask_q <= mask_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign word_o        = word_q;
    assign dp_o          = dp_q;
    assign frame_valid_o = fv_q;
    assign digit_mask_o  = mask_q;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans plus random scan traffic against a digit-level reference model.
`default_nettype none

module tb_seg_scan_decoder;

    localparam int STABLE_CYCLES = 4;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG_DEC_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an_i = 8'hFF;
    logic [7:0]  seg_i = 8'hFF;
    logic        clr_err_i = 1'b0;
    logic [31:0] word_o;
    logic [7:0]  dp_o;
    logic        frame_valid_o;
    logic [7:0]  digit_mask_o;
    logic        err_o;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE_CYCLES)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .an_i          (an_i),
        .seg_i         (seg_i),
        .clr_err_i     (clr_err_i),
        .word_o        (word_o),
        .dp_o          (dp_o),
        .frame_valid_o (frame_valid_o),
        .digit_mask_o  (digit_mask_o),
        .err_o         (err_o)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int fv_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: digit-level view of what the display currently shows.
    logic [31:0] m_word;
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;
    bit          m_fv, m_err, m_coll;
    logic [3:0]  m_nib [8];
    bit          m_sdp [8];
    logic [15:0] m_last;
    bit          m_last_ok;
    int          m_run;
    bit          m_pend;
    logic [7:0]  m_pan, m_pseg;

    task automatic model_reset();
        m_word = 32'h0; m_dp = 8'h00; m_mask = 8'h00;
        m_fv = 0; m_err = 0; m_coll = 0;
        m_last_ok = 0; m_run = 0; m_pend = 0;
        for (int i = 0; i < 8; i++) begin
            m_nib[i] = 4'h0;
            m_sdp[i] = 0;
        end
    endtask

    task automatic model_accept(input logic [7:0] a, input logic [7:0] s, output bit e);
        int zeros, d, nib;
        bit ok, dpl;
        e = 0; zeros = 0; d = 0; nib = 0; ok = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                d = i;
            end
        end
        if (zeros == 0) return;
        if (zeros > 1) begin
            e = 1;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (SEG_TAB[k] == s[6:0]) begin
                nib = k;
                ok = 1;
            end
        end
        if (!ok) e = 1;
        dpl = DP_EN && !s[7];
        if (!m_coll && d != 0) return;
        m_coll = 1;
        m_nib[d] = 4'(nib);
        m_sdp[d] = dpl;
        if (d == 0) begin
            m_mask = 8'h01;
            return;
        end
        m_mask[d] = 1'b1;
        if (m_mask == 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
                m_word[4*i +: 4] = m_nib[i];
                m_dp[i] = m_sdp[i];
            end
            m_fv = 1;
            m_mask = 8'h00;
        end
    endtask

    // A value shown for STABLE_CYCLES consecutive clocks is accepted; its effect lands one clock later.
    task automatic model_edge(input logic r, input logic c, input logic [7:0] a, input logic [7:0] s);
        bit e;
        logic [15:0] key;
        if (r) begin
            model_reset();
            return;
        end
        e = 0;
        m_fv = 0;
        if (m_pend) model_accept(m_pan, m_pseg, e);
        m_err = (m_err && !c) || e;
        key = {a, (DP_EN ? s : (s & 8'h7F))};
        if (m_last_ok && key == m_last) m_run++;
        else m_run = 1;
        m_last = key;
        m_last_ok = 1;
        m_pend = (m_run == STABLE_CYCLES);
        m_pan = key[15:8];
        m_pseg = key[7:0];
    endtask

    task automatic step(input logic r, input logic c, input logic [7:0] a, input logic [7:0] s);
        @(negedge clk);
        rst = r; clr_err_i = c; an_i = a; seg_i = s;
        @(posedge clk);
        model_edge(r, c, a, s);
        #1;
        if (frame_valid_o === 1'b1) fv_seen++;
        check("word", word_o, m_word);
        check("dp", {24'h0, dp_o}, {24'h0, m_dp});
        check("frame_valid", {31'h0, frame_valid_o}, {31'h0, m_fv});
        check("mask", {24'h0, digit_mask_o}, {24'h0, m_mask});
        check("err", {31'h0, err_o}, {31'h0, m_err});
    endtask

    task automatic show(input int d, input logic [3:0] nib, input bit dp, input int n);
        logic [7:0] a;
        a = 8'h01 << d;
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, ~a, {~dp, SEG_TAB[nib]});
    endtask

    task automatic scan(input logic [31:0] w, input logic [7:0] dpm, input int n);
        for (int i = 0; i < 8; i++) show(i, w[4*i +: 4], dpm[i], n);
    endtask

    int fv0;
    int d, r, h;
    logic [7:0] a, s;

    initial begin
        model_reset();
        // reset with random inputs
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        check("rst_word", word_o, 32'h0);
        check("rst_mask", {24'h0, digit_mask_o}, 32'h0);

        // two full scans of 0x1234ABCD
        fv0 = fv_seen;
        scan(32'h1234ABCD, 8'h00, 8);
        check("t2_word1", word_o, 32'h1234ABCD);
        scan(32'h1234ABCD, 8'h00, 8);
        check("t2_pulses", 32'(fv_seen - fv0), 32'd2);
        check("t2_word2", word_o, 32'h1234ABCD);
        check("t2_err", {31'h0, err_o}, 32'h0);

        // digit 2 held too briefly
        show(0, 4'h5, 0, 8);
        show(1, 4'h6, 0, 8);
        show(2, 4'h7, 0, 2);
        show(3, 4'h8, 0, 8);
        check("t3_mask", {24'h0, digit_mask_o}, 32'h0B);

        // unknown pattern on digit 3
        show(2, 4'h7, 0, 8);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, 8'hF7, 8'hFF);
        check("t4_err", {31'h0, err_o}, 32'h1);
        for (int i = 4; i < 8; i++) show(i, 4'(i), 0, 8);
        check("t4_nib3", {28'h0, word_o[15:12]}, 32'h0);
        check("t4_word", word_o, 32'h7654_0765);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        check("t4_clr", {31'h0, err_o}, 32'h0);

        // illegal AN code, then restart at digit 0
        show(0, 4'h1, 0, 8);
        show(1, 4'h2, 0, 8);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, 8'hF3, {1'b1, SEG_TAB[3]});
        check("t5_err", {31'h0, err_o}, 32'h1);
        check("t5_mask", {24'h0, digit_mask_o}, 32'h03);
        show(0, 4'h9, 0, 8);
        check("t5_restart", {24'h0, digit_mask_o}, 32'h01);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);

        // reset mid-frame, then 0xDEADBEEF with DP on digits 0 and 7
        for (int i = 1; i < 5; i++) show(i, 4'hC, 0, 8);
        step(1'b1, 1'b0, 8'hFE, 8'h40);
        step(1'b1, 1'b0, 8'hFE, 8'h40);
        check("t6_rst_mask", {24'h0, digit_mask_o}, 32'h0);
        check("t6_rst_word", word_o, 32'h0);
        scan(32'hDEADBEEF, 8'h81, 8);
        check("t6_word", word_o, 32'hDEADBEEF);
        check("t6_dp", {24'h0, dp_o}, DP_EN ? 32'h81 : 32'h00);

        // random scan traffic
        d = 0;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80) d = (d + 1) % 8;
            else d = int'($urandom_range(0, 7));
            a = 8'h01 << d;
            a = ~a;
            if (r % 23 == 0) a = 8'hFF;
            else if (r % 29 == 0) a = 8'($urandom);
            s = {1'($urandom), SEG_TAB[$urandom_range(0, 15)]};
            if ($urandom_range(0, 19) == 0) s = 8'($urandom);
            h = int'($urandom_range(1, 8));
            for (int j = 0; j < h; j++)
                step($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0, a, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
